// File: rtl/rat_intr_pkg.sv
// Shared types and constants for the RAT interrupt controller.
// The cause-readback option is selected by RAT_INTR_CAUSE_RD_EN in rat_intr_ctrl.
package rat_intr_pkg;

    localparam int         MAX_SRC       = 8;
    localparam logic [7:0] DEF_MASK_PORT = 8'h30;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } intr_state_t;

    // Index 0 is the highest priority, so the lowest set bit wins.
    function automatic logic [2:0] lowest_set(input logic [MAX_SRC-1:0] v);
        lowest_set = 3'd0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = 3'(i);
        end
    endfunction

endpackage

// File: rtl/rat_intr_ctrl_if.sv
// Bundle of IRQ lines, control-unit handshake and IO bus seen by the interrupt controller.
interface rat_intr_ctrl_if #(
    parameter int N_SRC = 4
);
    logic [N_SRC-1:0] IRQ_IN;
    logic             I_SET;
    logic             I_CLR;
    logic             INT_ACK;
    logic [7:0]       PORT_ID;
    logic [7:0]       OUT_PORT;
    logic             IO_STRB;
    logic             INT_CU;
    logic [2:0]       INT_SRC;
    logic             I_EN;
    logic [7:0]       IN_PORT_INT;

    modport master (
        output IRQ_IN, I_SET, I_CLR, INT_ACK, PORT_ID, OUT_PORT, IO_STRB,
        input  INT_CU, INT_SRC, I_EN, IN_PORT_INT
    );

    modport slave (
        input  IRQ_IN, I_SET, I_CLR, INT_ACK, PORT_ID, OUT_PORT, IO_STRB,
        output INT_CU, INT_SRC, I_EN, IN_PORT_INT
    );
endinterface

// File: rtl/intr_sync.sv
// One IRQ line: multi-flop synchroniser followed by a rising-edge detector.
module intr_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic i_irq,
    output logic o_edge
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/rat_intr_ctrl.sv
// Fixed-priority interrupt controller driving INT_CU to the RAT control unit.
// Define RAT_INTR_CAUSE_RD_EN to expose the pending vector at IO address MASK_PORT+1.
module rat_intr_ctrl
    import rat_intr_pkg::*;
#(
    parameter int         N_SRC       = 4,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] MASK_PORT   = DEF_MASK_PORT
) (
    input logic           CLK,
    input logic           RESET_N,
    rat_intr_ctrl_if.slave bus
);
    intr_state_t          r_state, w_state_nxt;
    logic [2:0]           r_src, w_src_nxt;
    logic                 r_ien, w_ien_nxt;
    logic [N_SRC-1:0]     r_pend, w_pend_nxt;
    logic [N_SRC-1:0]     r_mask, w_mask_nxt;
    logic [N_SRC-1:0]     w_edge;
    logic [N_SRC-1:0]     w_src_onehot;
    logic [N_SRC-1:0]     w_req;
    logic [MAX_SRC-1:0]   w_req_ext;
    logic                 w_mask_wr;
    logic                 w_unused;

    for (genvar g = 0; g < N_SRC; g++) begin : g_sync
        intr_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .CLK    (CLK),
            .RESET_N(RESET_N),
            .i_irq  (bus.IRQ_IN[g]),
            .o_edge (w_edge[g])
        );
    end

    always_comb begin
        w_mask_wr  = bus.IO_STRB && (bus.PORT_ID == MASK_PORT);
        w_mask_nxt = w_mask_wr ? bus.OUT_PORT[N_SRC-1:0] : r_mask;

        w_ien_nxt = r_ien;
        if (bus.I_CLR || bus.INT_ACK) w_ien_nxt = 1'b0;
        else if (bus.I_SET)           w_ien_nxt = 1'b1;

        for (int i = 0; i < N_SRC; i++) begin
            w_src_onehot[i] = (r_src == 3'(i));
        end

        // A new edge on the source being acknowledged must not be lost.
        w_pend_nxt = (r_pend & ~(bus.INT_ACK ? w_src_onehot : '0)) | w_edge;

        w_req                = r_pend & r_mask;
        w_req_ext            = '0;
        w_req_ext[N_SRC-1:0] = w_req;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        case (r_state)
            ST_IDLE: begin
                if (r_ien && (|w_req)) begin
                    w_state_nxt = ST_ASSERT;
                    w_src_nxt   = lowest_set(w_req_ext);
                end
            end
            ST_ASSERT: begin
                // Withdraw the request as soon as the CU disables or the winner is masked.
                if (bus.INT_ACK)                                 w_state_nxt = ST_SERVICE;
                else if (!w_ien_nxt || !(|(w_mask_nxt & w_src_onehot))) w_state_nxt = ST_IDLE;
            end
            ST_SERVICE: begin
                if (bus.I_SET) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_src   <= 3'd0;
            r_ien   <= 1'b0;
            r_pend  <= '0;
            r_mask  <= '1;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_ien   <= w_ien_nxt;
            r_pend  <= w_pend_nxt;
            r_mask  <= w_mask_nxt;
        end
    end

    assign bus.INT_CU  = (r_state == ST_ASSERT);
    assign bus.INT_SRC = r_src;
    assign bus.I_EN    = r_ien;

`ifdef RAT_INTR_CAUSE_RD_EN
    localparam logic [7:0] CAUSE_PORT = MASK_PORT + 8'd1;
    logic [7:0] w_cause;

    always_comb begin
        w_cause              = '0;
        w_cause[N_SRC-1:0]   = r_pend;
    end

    assign bus.IN_PORT_INT = (bus.PORT_ID == CAUSE_PORT) ? w_cause : 8'h00;
`else
    assign bus.IN_PORT_INT = 8'h00;
`endif

    // Upper OUT_PORT bits are intentionally ignored when N_SRC < 8.
    assign w_unused = ^bus.OUT_PORT;

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Randomised and directed bench for rat_intr_ctrl against a cycle-level behavioural model.
module tb_rat_intr_ctrl;
    localparam int         N  = 4;
    localparam int         S  = 2;
    localparam logic [7:0] MP = 8'h30;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    rat_intr_ctrl_if #(.N_SRC(N)) bus ();

    rat_intr_ctrl #(
        .N_SRC(N), .SYNC_STAGES(S), .MASK_PORT(MP)
    ) dut (
        .CLK(clk), .RESET_N(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: IRQ history, pending/mask/enable sets and a request phase.
    logic [N-1:0] m_hist [0:S];
    logic [N-1:0] m_pend, m_mask;
    bit           m_ien;
    int           m_phase;   // 0 waiting, 1 requesting, 2 in ISR
    int           m_src;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k <= S; k++) m_hist[k] = '0;
        m_pend  = '0;
        m_mask  = '1;
        m_ien   = 0;
        m_phase = 0;
        m_src   = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] rises, mask_after, req;
        bit           ien_after;
        int           old_src;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rises      = m_hist[S-1] & ~m_hist[S];
        ien_after  = (bus.I_CLR || bus.INT_ACK) ? 1'b0 : (bus.I_SET ? 1'b1 : m_ien);
        mask_after = (bus.IO_STRB && bus.PORT_ID == MP) ? bus.OUT_PORT[N-1:0] : m_mask;
        req        = m_pend & m_mask;
        old_src    = m_src;
        if (m_phase == 0) begin
            if (m_ien && req != 0) begin
                m_phase = 1;
                for (int i = N - 1; i >= 0; i--) if (req[i]) m_src = i;
            end
        end else if (m_phase == 1) begin
            if (bus.INT_ACK)                          m_phase = 2;
            else if (!ien_after || !mask_after[m_src]) m_phase = 0;
        end else begin
            if (bus.I_SET) m_phase = 0;
        end
        if (bus.INT_ACK) m_pend[old_src] = 1'b0;
        m_pend = m_pend | rises;
        m_ien  = ien_after;
        m_mask = mask_after;
        for (int k = S; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = bus.IRQ_IN;
    endtask

    task automatic compare_all();
        logic [7:0] exp_cause;
        exp_cause = 8'h00;
`ifdef RAT_INTR_CAUSE_RD_EN
        if (bus.PORT_ID == MP + 8'd1) exp_cause = {{(8-N){1'b0}}, m_pend};
`endif
        chk("int_cu",  32'(bus.INT_CU),      32'(m_phase == 1));
        chk("int_src", 32'(bus.INT_SRC),     32'(m_src));
        chk("i_en",    32'(bus.I_EN),        32'(m_ien));
        chk("cause",   32'(bus.IN_PORT_INT), 32'(exp_cause));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic pulse_set();  bus.I_SET = 1;   tick(); bus.I_SET = 0;   endtask
    task automatic pulse_ack();  bus.INT_ACK = 1; tick(); bus.INT_ACK = 0; endtask

    task automatic write_mask(input logic [7:0] v);
        bus.PORT_ID = MP; bus.OUT_PORT = v; bus.IO_STRB = 1;
        tick();
        bus.IO_STRB = 0; bus.PORT_ID = MP + 8'd1;
    endtask

    task automatic wait_int(input string tag);
        int n = 0;
        while (!bus.INT_CU && n < 30) begin tick(); n++; end
        chk({tag, "_raised"}, 32'(bus.INT_CU), 32'd1);
    endtask

    initial begin
        int cnt;
        rst_n = 0;
        bus.IRQ_IN = '0; bus.I_SET = 0; bus.I_CLR = 0; bus.INT_ACK = 0;
        bus.PORT_ID = MP + 8'd1; bus.OUT_PORT = 8'h00; bus.IO_STRB = 0;
        model_reset();
        @(negedge clk);
        tick(); tick();
        chk("rst_int_cu", 32'(bus.INT_CU), 32'd0);
        chk("rst_i_en",   32'(bus.I_EN),   32'd0);
        rst_n = 1;
        tick();

        // Single source latency and acknowledge
        pulse_set();
        bus.IRQ_IN[2] = 1;
        cnt = 0;
        do begin tick(); cnt++; end while (!bus.INT_CU && cnt < 20);
        chk("t1_latency", 32'(cnt), 32'(S + 2));
        chk("t1_src", 32'(bus.INT_SRC), 32'd2);
        pulse_ack();
        chk("t1_ack_cu",  32'(bus.INT_CU), 32'd0);
        chk("t1_ack_ien", 32'(bus.I_EN),   32'd0);

        // Simultaneous sources: priority then RETIE re-raise
        bus.IRQ_IN = '0; repeat (4) tick();
        pulse_set();
        bus.IRQ_IN = 4'b1010;
        wait_int("t2a");
        chk("t2_src_hi", 32'(bus.INT_SRC), 32'd1);
        pulse_ack(); pulse_set();
        wait_int("t2b");
        chk("t2_src_lo", 32'(bus.INT_SRC), 32'd3);
        pulse_ack(); pulse_set();

        // Masked source pends but does not request
        bus.IRQ_IN = '0; repeat (4) tick();
        write_mask(8'h0E);
        bus.IRQ_IN[0] = 1;
        repeat (8) tick();
        chk("t3_masked", 32'(bus.INT_CU), 32'd0);
        write_mask(8'h0F);
        wait_int("t3");
        chk("t3_src", 32'(bus.INT_SRC), 32'd0);
        pulse_ack(); pulse_set();

        // CLI while requesting withdraws, SEI re-raises
        bus.IRQ_IN = '0; repeat (4) tick();
        bus.IRQ_IN[3] = 1;
        wait_int("t4a");
        bus.I_CLR = 1; tick(); bus.I_CLR = 0;
        chk("t4_withdrawn", 32'(bus.INT_CU), 32'd0);
        pulse_set();
        wait_int("t4b");
        chk("t4_src", 32'(bus.INT_SRC), 32'd3);
        pulse_ack(); pulse_set();

        // New edge coincident with ack stays pending
        bus.IRQ_IN = '0; repeat (4) tick();
        bus.IRQ_IN[1] = 1;
        wait_int("t5a");
        bus.IRQ_IN[1] = 0; repeat (S + 2) tick();
        bus.IRQ_IN[1] = 1; repeat (S) tick();
        pulse_ack();
        pulse_set();
        wait_int("t5b");
        chk("t5_src", 32'(bus.INT_SRC), 32'd1);
        pulse_ack();

        // Reset during service restores enable, state and mask
        write_mask(8'h00);
        rst_n = 0; tick();
        chk("t6_cu",  32'(bus.INT_CU), 32'd0);
        chk("t6_ien", 32'(bus.I_EN),   32'd0);
        rst_n = 1;
        bus.IRQ_IN = '0; repeat (4) tick();
        pulse_set();
        bus.IRQ_IN[3] = 1;
        wait_int("t6");
        chk("t6_src", 32'(bus.INT_SRC), 32'd3);
        pulse_ack(); pulse_set();

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) bus.IRQ_IN[b] = ~bus.IRQ_IN[b];
            bus.I_SET   = ($urandom_range(0, 5) == 0);
            bus.I_CLR   = ($urandom_range(0, 11) == 0);
            bus.INT_ACK = (m_phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 2))
                0:       bus.PORT_ID = MP;
                1:       bus.PORT_ID = MP + 8'd1;
                default: bus.PORT_ID = 8'($urandom);
            endcase
            bus.OUT_PORT = 8'($urandom);
            bus.IO_STRB  = ($urandom_range(0, 5) == 0);
            rst_n        = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
